seq_detector_param: RTL

- Parametrised serial pattern detector for slow board inputs (push-buttons, switches) on the 50 MHz board clock.
- Synchronises a raw input and samples it on an internal prescaler tick.
- Matches the last PATTERN_LEN samples against a configurable pattern, with overlapping or non-overlapping detection.
- Reports a one-cycle detect pulse, a sticky LED flag and a saturating match count. Instanced in the lab top level, replacing hand-coded fixed-pattern FSMs and free-running divider counters.

---
 rtl/seq_pkg.sv | 20 ++
 rtl/seq_detector_param_tick_gen.sv | 38 +++
 rtl/seq_detector_param.sv | 103 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared constants and helpers for the serial pattern detector family.
// Latency: n/a (package only).
// Backpressure: n/a.
package seq_pkg;

    localparam int MAX_PATTERN_LEN = 16;
    localparam int FILL_W          = 5;
    localparam int MAX_CNT_W       = 32;

    // Increment that sticks at the all-ones value of a counter 'width' bits wide.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] value,
        input int unsigned          width
    );
        logic [MAX_CNT_W-1:0] max_v;
        max_v = (width >= MAX_CNT_W) ? '1 : ((MAX_CNT_W'(1) << width) - MAX_CNT_W'(1));
        return (value == max_v) ? value : value + MAX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/seq_detector_param_tick_gen.sv
// Prescaler: one-cycle registered tick every DIV_MAX+1 enabled cycles.
// Latency: tick is high the cycle after the counter sits at DIV_MAX.
// Backpressure: none; en=0 freezes the count and holds tick low.
module tick_gen #(
    parameter int unsigned DIV_MAX   = 24999999,
    parameter int          DIV_WIDTH = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_WIDTH-1:0] DIV_TC = DIV_WIDTH'(DIV_MAX);

    if (DIV_WIDTH < 1 || DIV_WIDTH > 32 ||
        64'(DIV_MAX) >= (64'd1 << DIV_WIDTH)) begin : g_bad_div
        $error("tick_gen: DIV_MAX does not fit in DIV_WIDTH bits");
    end

    logic [DIV_WIDTH-1:0] div;
    logic                 at_tc;

    assign at_tc = (div == DIV_TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= en && at_tc;
            if (en) begin
                div <= at_tc ? '0 : div + DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector for slow board inputs: sync, prescaled sampling, match.
// Latency: din -> 2 sync flops -> shift on next tick edge -> detect the cycle after.
// Backpressure: none; en=0 holds prescaler and history, clr clears led/count.
module seq_detector_param
    import seq_pkg::*;
#(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter bit                     OVERLAP     = 1'b1,
    parameter int unsigned            DIV_MAX     = 24999999,
    parameter int                     DIV_WIDTH   = 25,
    parameter int                     CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 din,
    input  logic                 clr,
    output logic                 detect,
    output logic                 led,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic [4:0]           fill,
    output logic                 tick
);

    localparam logic [FILL_W-1:0] FULL = FILL_W'(PATTERN_LEN);

    if (PATTERN_LEN < 1 || PATTERN_LEN > MAX_PATTERN_LEN) begin : g_bad_len
        $error("seq_detector_param: PATTERN_LEN must be 1..16");
    end
    if (CNT_WIDTH < 1 || CNT_WIDTH > MAX_CNT_W) begin : g_bad_cnt
        $error("seq_detector_param: CNT_WIDTH must be 1..32");
    end

    logic                   din_meta;
    logic                   din_s;
    logic [PATTERN_LEN-1:0] hist;
    logic [PATTERN_LEN-1:0] hist_next;
    logic [PATTERN_LEN:0]   shifted;
    logic [FILL_W-1:0]      fill_next;
    logic                   match;

    tick_gen #(
        .DIV_MAX   (DIV_MAX),
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_meta <= 1'b0;
            din_s    <= 1'b0;
        end else begin
            din_meta <= din;
            din_s    <= din_meta;
        end
    end

    // One bit wider than hist so the slice also works for PATTERN_LEN=1.
    assign shifted = {hist, din_s};

    always_comb begin
        hist_next = hist;
        fill_next = fill;
        match     = 1'b0;
        if (tick) begin
            hist_next = shifted[PATTERN_LEN-1:0];
            fill_next = (fill == FULL) ? FULL : fill + FILL_W'(1);
            match     = (fill_next == FULL) && (hist_next == PATTERN);
            if (match && !OVERLAP) begin
                fill_next = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist        <= '0;
            fill        <= '0;
            detect      <= 1'b0;
            led         <= 1'b0;
            match_count <= '0;
        end else begin
            hist   <= hist_next;
            fill   <= fill_next;
            detect <= match;
            // A match on the clearing edge restarts the count at one.
            if (match) begin
                led         <= 1'b1;
                match_count <= clr ? CNT_WIDTH'(1)
                                   : CNT_WIDTH'(sat_inc(MAX_CNT_W'(match_count), CNT_WIDTH));
            end else if (clr) begin
                led         <= 1'b0;
                match_count <= '0;
            end
        end
    end

endmodule
